// File: rtl/gaussian_rd_engine_if.sv
// gaussian_rd_engine_if: control, CCI-P c0 request/response and line-output signals of the read engine.
interface gaussian_rd_engine_if #(
    parameter int ADDR_W = 42,
    parameter int CNT_W  = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_lines;
    logic              busy;
    logic              done;
    logic              c0_req_valid;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [15:0]       c0_req_mdata;
    logic              c0_almfull;
    logic              c0_rsp_valid;
    logic [15:0]       c0_rsp_mdata;
    logic [511:0]      c0_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_idx;
    logic [511:0]      out_data;
    modport master (
        output start, base_addr, num_lines, c0_almfull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, out_ready,
        input  busy, done, c0_req_valid, c0_req_addr, c0_req_mdata, out_valid, out_idx, out_data
    );
    modport slave (
        input  start, base_addr, num_lines, c0_almfull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, out_ready,
        output busy, done, c0_req_valid, c0_req_addr, c0_req_mdata, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/gaussian_rd_engine.sv
// gaussian_rd_engine: credit-limited CCI-P c0 line reader feeding a first-word-fall-through response FIFO.
// Define GAUSSIAN_RD_PERF_EN to add saturating stall/busy performance counters.
module gaussian_rd_engine #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42,
    parameter int CNT_W           = 32
) (
    input logic                 pClk,
    input logic                 reset,
`ifdef GAUSSIAN_RD_PERF_EN
    output logic [31:0]         perf_stall_cycles_o,
    output logic [31:0]         perf_busy_cycles_o,
`endif
    gaussian_rd_engine_if.slave rd_if
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int DW = 16 + 512;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q, addr_q;
    logic [CNT_W-1:0]  num_q, issued_q, accepted_q;
    logic [CW-1:0]     inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]     wr_q, rd_q;
    logic [15:0]       mdata_q;
    logic              req_q, busy_q, done_q;
    logic [DW-1:0]     mem [MAX_OUTSTANDING];
    logic              can_issue, rsp_ok, push, pop;

    // Credits count both lines in flight and lines parked in the FIFO, so the FIFO can never overflow.
    always_comb begin
        can_issue  = state_q == ISSUE && !rd_if.c0_almfull && issued_q < num_q
                     && {1'b0, inflight_q} + {1'b0, count_q} < (CW+1)'(MAX_OUTSTANDING);
        rsp_ok     = rd_if.c0_rsp_valid && (state_q == ISSUE || state_q == DRAIN) && inflight_q != '0;
        push       = rsp_ok && count_q != CW'(MAX_OUTSTANDING);
        pop        = count_q != '0 && rd_if.out_ready;
        inflight_d = inflight_q + CW'(can_issue) - CW'(rsp_ok);
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge pClk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            mdata_q    <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            req_q      <= can_issue;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_q       <= wr_q + PW'(push);
            rd_q       <= rd_q + PW'(pop);
            accepted_q <= accepted_q + CNT_W'(pop);
            if (can_issue) begin
                addr_q   <= base_q + ADDR_W'(issued_q);
                mdata_q  <= issued_q[15:0];
                issued_q <= issued_q + 1'b1;
            end
            case (state_q)
                IDLE: if (rd_if.start) begin
                    base_q     <= rd_if.base_addr;
                    num_q      <= rd_if.num_lines;
                    issued_q   <= '0;
                    accepted_q <= '0;
                    state_q    <= rd_if.num_lines == '0 ? DONE : ISSUE;
                    busy_q     <= 1'b1;
                    done_q     <= rd_if.num_lines == '0;
                end
                ISSUE: if (can_issue && issued_q == num_q - 1'b1) state_q <= DRAIN;
                DRAIN: if (accepted_q + CNT_W'(pop) == num_q) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pClk) begin
        if (push) mem[wr_q] <= {rd_if.c0_rsp_mdata, rd_if.c0_rsp_data};
    end

    assert property (@(posedge pClk) disable iff (reset) !(rsp_ok && count_q == CW'(MAX_OUTSTANDING)));

    assign rd_if.busy         = busy_q;
    assign rd_if.done         = done_q;
    assign rd_if.c0_req_valid = req_q;
    assign rd_if.c0_req_addr  = addr_q;
    assign rd_if.c0_req_mdata = mdata_q;
    assign rd_if.out_valid    = count_q != '0;
    assign {rd_if.out_idx, rd_if.out_data} = count_q != '0 ? mem[rd_q] : '0;

`ifdef GAUSSIAN_RD_PERF_EN
    logic [31:0] stall_q, busy_cnt_q;

    always_ff @(posedge pClk or posedge reset) begin
        if (reset) begin
            stall_q    <= '0;
            busy_cnt_q <= '0;
        end else if (state_q == IDLE && rd_if.start) begin
            stall_q    <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (state_q == ISSUE && issued_q < num_q && !can_issue && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (busy_q && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cycles_o = stall_q;
    assign perf_busy_cycles_o  = busy_cnt_q;
`endif
endmodule
